// File: rtl/udma_spim_clk_pkg.sv
// Shared types and default widths for the uDMA SPI master clock generator.
package udma_spim_clk_pkg;

   localparam int DEF_DIV_WIDTH = 8;
   localparam int DEF_CNT_WIDTH = 16;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

endpackage

// File: rtl/udma_spim_clk_gen_if.sv
// Controller-side bundle of the SPI clock generator: config, burst handshake, SCK and strobes.
interface udma_spim_clk_gen_if
   import udma_spim_clk_pkg::*;
#(
   parameter int DIV_WIDTH = DEF_DIV_WIDTH,
   parameter int CNT_WIDTH = DEF_CNT_WIDTH
) ();

   logic [DIV_WIDTH-1:0] cfg_div_i;
   logic                 cfg_cpol_i;
   logic                 cfg_valid_i;
   logic                 start_valid_i;
   logic                 start_ready_o;
   logic [CNT_WIDTH-1:0] num_cycles_i;
   logic                 en_i;
   logic                 stop_i;
   logic                 sck_o;
   logic                 lead_o;
   logic                 trail_o;
   logic                 busy_o;
   logic                 done_o;

   modport master (
      output cfg_div_i, cfg_cpol_i, cfg_valid_i, start_valid_i, num_cycles_i, en_i, stop_i,
      input  start_ready_o, sck_o, lead_o, trail_o, busy_o, done_o
   );

   modport slave (
      input  cfg_div_i, cfg_cpol_i, cfg_valid_i, start_valid_i, num_cycles_i, en_i, stop_i,
      output start_ready_o, sck_o, lead_o, trail_o, busy_o, done_o
   );

endinterface

// File: rtl/udma_spim_clk_tick.sv
// Half-period counter: combinational tick in the cycle the count reaches half-1; holds while en is low.
module udma_spim_clk_tick
   import udma_spim_clk_pkg::*;
#(
   parameter int DIV_WIDTH = DEF_DIV_WIDTH
) (
   input  logic                 clk_i,
   input  logic                 rstn_i,
   input  logic                 clear,
   input  logic                 en,
   input  logic [DIV_WIDTH-1:0] half,
   output logic                 tick
);

   logic [DIV_WIDTH-1:0] cnt_q;

   // half is guaranteed >= 1 by the caller, so half-1 never wraps
   assign tick = en && !clear && (cnt_q == half - DIV_WIDTH'(1));

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         cnt_q <= '0;
      end else if (clear) begin
         cnt_q <= '0;
      end else if (en) begin
         cnt_q <= tick ? '0 : cnt_q + DIV_WIDTH'(1);
      end
   end

endmodule

// File: rtl/udma_spim_clk_gen.sv
// SPI clock generator: bursts of N SCK periods with coincident lead/trail strobes and a done pulse.
// First edge after `half` enabled cycles in RUN; en low freezes everything, stop ends at next trailing edge.
module udma_spim_clk_gen
   import udma_spim_clk_pkg::*;
#(
   parameter int DIV_WIDTH = DEF_DIV_WIDTH,
   parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
   input  logic                clk_i,
   input  logic                rstn_i,
   udma_spim_clk_gen_if.slave  bus
);

   typedef struct packed {
      logic [DIV_WIDTH-1:0] div;
      logic                 cpol;
   } cfg_t;

   state_e               state_q, state_d;
   cfg_t                 cfg_q, cfg_d;
   cfg_t                 shd_q, shd_d;
   cfg_t                 cfg_in, cfg_end;
   logic                 pend_q, pend_d;
   logic                 stop_q, stop_d;
   logic                 sck_q, sck_d;
   logic                 lead_q, lead_d;
   logic                 trail_q, trail_d;
   logic                 done_q, done_d;
   logic [CNT_WIDTH-1:0] rem_q, rem_d;
   logic [DIV_WIDTH-1:0] half;
   logic                 tick;
   logic                 start_hs;

   assign cfg_in   = {bus.cfg_div_i, bus.cfg_cpol_i};
   // a write landing in the final RUN cycle wins over the older shadow value
   assign cfg_end  = bus.cfg_valid_i ? cfg_in : shd_q;
   assign half     = (cfg_q.div == '0) ? DIV_WIDTH'(1) : cfg_q.div;
   assign start_hs = bus.start_valid_i && (state_q == IDLE);

   udma_spim_clk_tick #(
      .DIV_WIDTH (DIV_WIDTH)
   ) u_tick (
      .clk_i  (clk_i),
      .rstn_i (rstn_i),
      .clear  (state_q != RUN),
      .en     (bus.en_i),
      .half   (half),
      .tick   (tick)
   );

   always_comb begin
      state_d = state_q;
      cfg_d   = cfg_q;
      shd_d   = shd_q;
      pend_d  = pend_q;
      stop_d  = stop_q;
      sck_d   = sck_q;
      rem_d   = rem_q;
      lead_d  = 1'b0;
      trail_d = 1'b0;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            stop_d = 1'b0;
            if (bus.cfg_valid_i) begin
               cfg_d = cfg_in;
               sck_d = cfg_in.cpol;
            end
            if (start_hs) begin
               rem_d = bus.num_cycles_i;
               if (bus.num_cycles_i == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            if (bus.cfg_valid_i) begin
               shd_d  = cfg_in;
               pend_d = 1'b1;
            end
            if (bus.stop_i) begin
               stop_d = 1'b1;
            end
            if (tick) begin
               sck_d = ~sck_q;
               if (sck_q == cfg_q.cpol) begin
                  lead_d = 1'b1;
               end else begin
                  trail_d = 1'b1;
                  rem_d   = rem_q - CNT_WIDTH'(1);
                  if ((rem_q == CNT_WIDTH'(1)) || stop_q || bus.stop_i) begin
                     done_d  = 1'b1;
                     state_d = IDLE;
                     stop_d  = 1'b0;
                     if (pend_q || bus.cfg_valid_i) begin
                        cfg_d  = cfg_end;
                        sck_d  = cfg_end.cpol;
                        pend_d = 1'b0;
                     end
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q <= IDLE;
         cfg_q   <= '{div: DIV_WIDTH'(1), cpol: 1'b0};
         shd_q   <= '{div: DIV_WIDTH'(1), cpol: 1'b0};
         pend_q  <= 1'b0;
         stop_q  <= 1'b0;
         sck_q   <= 1'b0;
         rem_q   <= '0;
         lead_q  <= 1'b0;
         trail_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cfg_q   <= cfg_d;
         shd_q   <= shd_d;
         pend_q  <= pend_d;
         stop_q  <= stop_d;
         sck_q   <= sck_d;
         rem_q   <= rem_d;
         lead_q  <= lead_d;
         trail_q <= trail_d;
         done_q  <= done_d;
      end
   end

   assign bus.sck_o         = sck_q;
   assign bus.lead_o        = lead_q;
   assign bus.trail_o       = trail_q;
   assign bus.done_o        = done_q;
   assign bus.start_ready_o = (state_q == IDLE);
   assign bus.busy_o        = (state_q == RUN);

endmodule

// File: doc/udma_spim_clk_gen.md
Name: udma_spim_clk_gen

Overview:
Parametrised SPI clock generator for the uDMA SPI master, replacing the free-running divider counter.
- Produces a burst of exactly N SCK periods on request, then pulses done.
- Programmable half-period, programmable idle polarity (CPOL), clock-enable freeze and graceful stop.
- Emits leading/trailing edge strobes so the TX/RX shifters can shift and sample without re-deriving edges from sck_o.
- Sits between the SPI master controller FSM and the pad-side SCK/shift logic.

Parameters:
DIV_WIDTH, 8, width of half-period divider value.
CNT_WIDTH, 16, width of SCK period count per burst.

Ports:
clk_i  in  1  system clock; only clock.
rstn_i  in  1  asynchronous active-low reset.
cfg_div_i  in  DIV_WIDTH  half-period length in clk_i cycles; 0 treated as 1.
cfg_cpol_i  in  1  SCK idle level.
cfg_valid_i  in  1  one-cycle config write strobe.
start_valid_i  in  1  burst request.
start_ready_o  out  1  high when idle and able to accept a burst.
num_cycles_i  in  CNT_WIDTH  SCK periods in the burst; sampled on handshake.
en_i  in  1  low freezes counter, SCK and strobes (backpressure).
stop_i  in  1  request early termination.
sck_o  out  1  registered SPI clock.
lead_o  out  1  strobe; high in the cycle sck_o leaves its idle level.
trail_o  out  1  strobe; high in the cycle sck_o returns to its idle level.
busy_o  out  1  burst in progress.
done_o  out  1  one-cycle burst-complete pulse.

Behaviour:
- Reset values: sck_o=0, lead_o=0, trail_o=0, busy_o=0, done_o=0, start_ready_o=1. Internally: div=1, cpol=0, no pending config, state IDLE.
- Reset mid-burst aborts immediately to these values. No done_o pulse.
- States:
  - IDLE -> RUN on start handshake (start_valid_i && start_ready_o) with num_cycles_i != 0.
  - IDLE -> IDLE on handshake with num_cycles_i == 0; done_o pulses the next cycle with no edges.
  - RUN -> IDLE on the last trailing edge.
- start_ready_o = (state == IDLE). busy_o = (state == RUN).
- Half-period counter (DIV_WIDTH bits):
  - Cleared on entering RUN.
  - When en_i is high: if counter == half-1, sck_o toggles and counter clears; otherwise counter increments.
  - half = max(cfg_div, 1).
  - When en_i is low: counter, sck_o and remaining count are held, and lead_o/trail_o stay 0.
- First leading edge is registered after `half` enabled cycles in RUN.
- lead_o/trail_o are registered together with the sck_o transition, so they are coincident at the outputs.
- Remaining count (CNT_WIDTH) is loaded from num_cycles_i and decremented on each trailing edge.
- On the trailing edge where remaining == 1:
  - done_o is high in that same output cycle.
  - Next state is IDLE; sck_o is already at cpol.
- stop_i:
  - In RUN it sets a sticky stop flag; the burst ends at the next trailing edge with done_o as normal.
  - If stop_i coincides with a trailing edge, that edge is the last.
  - Ignored in IDLE, including when it coincides with a start handshake.
- Config writes:
  - cfg_valid_i in IDLE: div and cpol are updated next cycle, and sck_o moves to the new cpol in that same next cycle.
  - cfg_valid_i in RUN: the values go to a shadow register with a pending flag; a later write overwrites them. They are applied in the cycle the state returns to IDLE.
  - A simultaneous cfg_valid_i and start handshake in IDLE: the new config applies to the burst being started.
- Widths: counter compares are unsigned, with no wrap. The remaining count never underflows: zero is only reachable through the IDLE shortcut.

Decomposition:
- Package udma_spim_clk_pkg:
  - state enum (IDLE, RUN).
  - localparams for default DIV_WIDTH/CNT_WIDTH.
  - cfg struct {div, cpol}, parametrised via the module parameter, not the package.
- Sub-module udma_spim_clk_tick:
  - DIV_WIDTH half-period counter.
  - Inputs: clear, en, half. Output: tick pulse.
  - The top level owns the FSM, SCK, strobes, count, stop and shadow config.

Test Plan:
- Basic burst: div=2, cpol=0, N=3, en_i=1.
  - sck_o is high for 2 cycles and low for 2 cycles each period.
  - 3 lead_o and 3 trail_o pulses.
  - done_o is coincident with the 3rd trail_o, 12 cycles after RUN entry; start_ready_o is high the next cycle.
- CPOL=1, div=0, N=2:
  - sck_o idles high and toggles every cycle (clk/2).
  - lead_o on the falling edges of sck_o; done_o after 4 cycles in RUN.
- en_i low for 5 cycles mid high-phase (div=3, N=2):
  - sck_o, counter and strobes are frozen.
  - Total burst length is 12 + 5 cycles.
- stop_i pulsed 1 cycle after the 1st lead_o with N=100:
  - Exactly 1 trail_o follows, then done_o, then IDLE.
  - stop_i asserted in IDLE has no effect on a following N=1 burst.
- cfg_valid_i (div=4, cpol=1) during a div=1 burst:
  - The current burst timing is unchanged.
  - In the done cycle sck_o goes 1, and the next burst uses half=4.
- num_cycles_i=0 handshake:
  - No edges; done_o pulses 1 cycle after the handshake.
- Reset mid-burst:
  - rstn_i low asynchronously forces sck_o=0, busy_o=0, done_o=0.
  - Pending config is discarded; cpol returns to 0.
